pulse_pattern_checker: RTL and testbench
========================================

PULSE_PATTERN_CHECKER -- requirements
Module: pulse_pattern_checker

Interface
REQ-001 Parameter DWELL, default 20, nominal phase length in clock cycles (legal range 2..1023).
REQ-002 Parameter TOL, default 2, allowed +/- deviation of each phase length in cycles (TOL < DWELL).
REQ-003 clk  input  1  single clock; all logic on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin checking a low-high-low pattern.
REQ-006 din  input  1  observed single-bit line; synchronous to clk, no synchronizer inside.
REQ-007 busy  output  1  high while a check is in progress.
REQ-008 done  output  1  one-cycle pulse when a check ends, whether it passes or fails.
REQ-009 pass  output  1  result of the last check; valid from done and held until the next accepted start.
REQ-010 fail_code  output  2  0 = none, 1 = LOW1 length bad, 2 = HIGH length bad, 3 = LOW2 glitch; held with pass.

Function
REQ-011 The FSM states shall be IDLE, LOW1, HIGH, LOW2 and RESULT.
REQ-012 IDLE: start=1 -> LOW1 on the next edge, with cnt=0, pass=0 and fail_code=0.
REQ-013 start is ignored while busy=1.
REQ-014 busy=1 in LOW1, HIGH and LOW2 only.
REQ-015 LOW1: each cycle with din=0 increments cnt.
REQ-016 LOW1: din=1 with cnt in [DWELL-TOL, DWELL+TOL] -> HIGH with cnt=1, because that cycle counts as high.
REQ-017 LOW1: din=1 with cnt outside the window -> RESULT with fail_code=1.
REQ-018 LOW1: cnt reaching DWELL+TOL+1 with din still 0 -> RESULT with fail_code=1.
REQ-019 HIGH applies the same rules as LOW1 with polarity inverted: din=1 counts, din=0 in the window -> LOW2 with cnt=1, otherwise fail_code=2.
REQ-020 LOW2: cnt reaching DWELL-TOL with din=0 throughout -> RESULT with pass=1; cycles after that are not examined.
REQ-021 LOW2: din=1 before that point -> RESULT with fail_code=3.
REQ-022 RESULT lasts exactly one cycle, asserts done=1, then returns to IDLE; a start in RESULT is ignored.
REQ-023 pass and fail_code are registered, update on the edge entering RESULT, and are mutually exclusive (pass=1 implies fail_code=0).
REQ-024 Latency: done rises on the edge after the sample that decides the outcome.
REQ-025 cnt width is clog2(DWELL+TOL+2); cnt saturates and never wraps.
REQ-026 When din changes and cnt reaches its limit in the same cycle, the din change has priority.

Reset
REQ-027 rst=1 at any clock edge shall force IDLE, cnt=0, busy=0, done=0, pass=0 and fail_code=0, including mid-check.
REQ-028 rst has priority over start; no done pulse is produced for an aborted check.

Structure
REQ-029 Package pulse_chk_pkg shall hold the state encoding and the four fail_code constants.
REQ-030 Sub-module phase_counter shall provide the clear/increment/saturate counter and its window compare outputs (in_window, too_long, min_reached).
REQ-031 All outputs are driven directly from flops; no combinational path from din to any output.

Verification (DWELL=20, TOL=2)
REQ-032 start, then din low 20, high 20, low 20 -> done after LOW2 sample 18, pass=1, fail_code=0.
REQ-033 start, then din low 17, then high -> done one cycle after the rising sample, pass=0, fail_code=1.
REQ-034 start, then low 20, high held 30 -> fail at HIGH cnt=23, fail_code=2.
REQ-035 start, then low 22, high 18, low 5, high -> fail_code=3.
REQ-036 rst pulsed during HIGH, then a new start and a legal pattern -> outputs clear with no done, then pass=1.
REQ-037 start re-pulsed while busy and during RESULT -> ignored; single done per check.

Source files
------------

// File: rtl/pulse_chk_pkg.sv
// Shared encodings for the pulse pattern checker: FSM states and result codes.
package pulse_chk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOW1   = 3'd1,
    ST_HIGH   = 3'd2,
    ST_LOW2   = 3'd3,
    ST_RESULT = 3'd4
  } state_t;

  localparam logic [1:0] FC_NONE = 2'd0;  // check passed or still running
  localparam logic [1:0] FC_LOW1 = 2'd1;  // first low phase length out of window
  localparam logic [1:0] FC_HIGH = 2'd2;  // high phase length out of window
  localparam logic [1:0] FC_LOW2 = 2'd3;  // high glitch during the final low phase

endpackage

// File: rtl/phase_counter.sv
// Phase length counter: clear / load-one / saturating increment, plus window
// compares.  too_long and min_reached look one counted sample ahead so the FSM
// can decide on the very sample that crosses the limit.
module phase_counter #(
  parameter int DWELL = 20,
  parameter int TOL   = 2,
  parameter int CW    = $clog2(DWELL + TOL + 2)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic load_one,
  input  logic inc,
  output logic in_window,
  output logic too_long,
  output logic min_reached
);

  localparam logic [CW-1:0] WIN_LO  = CW'(DWELL - TOL);
  localparam logic [CW-1:0] WIN_HI  = CW'(DWELL + TOL);
  localparam logic [CW-1:0] CNT_MAX = CW'(DWELL + TOL + 1);
  localparam logic [CW-1:0] MIN_PRE = CW'(DWELL - TOL - 1);

  logic [CW-1:0] cnt;

  // Counter register; saturates at DWELL+TOL+1 instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= {CW{1'b0}};
    end else if (clr) begin
      cnt <= {CW{1'b0}};
    end else if (load_one) begin
      cnt <= CW'(1);
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CW'(1);
    end else begin
      cnt <= cnt;
    end
  end

  assign in_window   = (cnt >= WIN_LO) && (cnt <= WIN_HI);
  assign too_long    = (cnt >= WIN_HI);   // one more counted sample exceeds the window
  assign min_reached = (cnt >= MIN_PRE);  // one more counted sample reaches the minimum

endmodule

// File: rtl/pulse_pattern_checker.sv
// Checks a low-high-low pulse on din after a start request; each phase must
// last DWELL +/- TOL cycles (the final low only needs DWELL-TOL cycles).
// All outputs come straight from flops.
module pulse_pattern_checker
  import pulse_chk_pkg::*;
#(
  parameter int DWELL = 20,
  parameter int TOL   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       din,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [1:0] fail_code
);

  localparam int CW = $clog2(DWELL + TOL + 2);

  state_t     state, state_next;
  logic       cnt_clr, cnt_load_one, cnt_inc;
  logic       in_window, too_long, min_reached;
  logic       accept, res_update, res_pass;
  logic [1:0] res_fc;

  phase_counter #(.DWELL(DWELL), .TOL(TOL), .CW(CW)) u_cnt (
    .clk         (clk),
    .rst         (rst),
    .clr         (cnt_clr),
    .load_one    (cnt_load_one),
    .inc         (cnt_inc),
    .in_window   (in_window),
    .too_long    (too_long),
    .min_reached (min_reached)
  );

  // Next-state and counter control; a level change outranks the length limit.
  always_comb begin
    state_next   = state;
    cnt_clr      = 1'b0;
    cnt_load_one = 1'b0;
    cnt_inc      = 1'b0;
    accept       = 1'b0;
    res_update   = 1'b0;
    res_pass     = 1'b0;
    res_fc       = FC_NONE;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_LOW1;
          cnt_clr    = 1'b1;
          accept     = 1'b1;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_LOW1: begin
        if (din) begin
          if (in_window) begin
            state_next   = ST_HIGH;
            cnt_load_one = 1'b1;
          end else begin
            state_next = ST_RESULT;
            res_update = 1'b1;
            res_fc     = FC_LOW1;
          end
        end else if (too_long) begin
          state_next = ST_RESULT;
          cnt_inc    = 1'b1;
          res_update = 1'b1;
          res_fc     = FC_LOW1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_HIGH: begin
        if (!din) begin
          if (in_window) begin
            state_next   = ST_LOW2;
            cnt_load_one = 1'b1;
          end else begin
            state_next = ST_RESULT;
            res_update = 1'b1;
            res_fc     = FC_HIGH;
          end
        end else if (too_long) begin
          state_next = ST_RESULT;
          cnt_inc    = 1'b1;
          res_update = 1'b1;
          res_fc     = FC_HIGH;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_LOW2: begin
        if (din) begin
          state_next = ST_RESULT;
          res_update = 1'b1;
          res_fc     = FC_LOW2;
        end else if (min_reached) begin
          state_next = ST_RESULT;
          cnt_inc    = 1'b1;
          res_update = 1'b1;
          res_pass   = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_RESULT: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and output registers; result is cleared on accept, loaded entering RESULT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_code <= FC_NONE;
    end else begin
      state <= state_next;
      busy  <= (state_next == ST_LOW1) || (state_next == ST_HIGH) || (state_next == ST_LOW2);
      done  <= (state_next == ST_RESULT);
      if (accept) begin
        pass      <= 1'b0;
        fail_code <= FC_NONE;
      end else if (res_update) begin
        pass      <= res_pass;
        fail_code <= res_fc;
      end else begin
        pass      <= pass;
        fail_code <= fail_code;
      end
    end
  end

endmodule

// File: tb/tb_pulse_pattern_checker.sv
// Testbench: run-length reference model of the low-high-low rules, compared
// against the DUT after every clock edge, plus literal expectations.
module tb_pulse_pattern_checker;

  localparam int DWELL = 20;
  localparam int TOL   = 2;
  localparam int LO    = DWELL - TOL;
  localparam int HI    = DWELL + TOL;

  logic       clk = 1'b0;
  logic       rst, start, din;
  logic       busy, done, pass;
  logic [1:0] fail_code;

  always #5 clk = ~clk;

  pulse_pattern_checker #(.DWELL(DWELL), .TOL(TOL)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .din       (din),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_code (fail_code)
  );

  int vectors     = 0;
  int miscompares = 0;
  int done_seen   = 0;

  // reference model state
  bit         m_active = 1'b0;
  bit         m_result = 1'b0;
  bit         q[$];
  bit         pat[$];
  int         m_decided_at = 0;
  logic       exp_busy = 1'b0, exp_done = 1'b0, exp_pass = 1'b0;
  logic [1:0] exp_fc = 2'd0;

  task automatic check(input string name, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Judge the samples of the current check by run lengths.
  function automatic void evaluate(output bit decided, output bit p, output logic [1:0] fc);
    int i = 0;
    int n = q.size();
    int a = 0, h = 0, m = 0;
    decided = 1'b0; p = 1'b0; fc = 2'd0;
    while (i < n && q[i] == 1'b0) begin a++; i++; end
    if (i == n) begin
      if (a > HI) begin decided = 1'b1; fc = 2'd1; end
      return;
    end
    if (a < LO || a > HI) begin decided = 1'b1; fc = 2'd1; return; end
    while (i < n && q[i] == 1'b1) begin h++; i++; end
    if (i == n) begin
      if (h > HI) begin decided = 1'b1; fc = 2'd2; end
      return;
    end
    if (h < LO || h > HI) begin decided = 1'b1; fc = 2'd2; return; end
    while (i < n && q[i] == 1'b0) begin m++; i++; end
    if (m >= LO) begin decided = 1'b1; p = 1'b1; return; end
    if (i < n) begin decided = 1'b1; fc = 2'd3; end
  endfunction

  // Expected outputs after the edge that sampled (s, d, r).
  task automatic model_step(input bit s, input bit d, input bit r);
    bit dec, p;
    logic [1:0] fc;
    if (r) begin
      m_active = 1'b0; m_result = 1'b0; q.delete();
      exp_busy = 1'b0; exp_done = 1'b0; exp_pass = 1'b0; exp_fc = 2'd0;
    end else if (m_result) begin
      m_result = 1'b0;
      exp_done = 1'b0;
    end else if (!m_active) begin
      if (s) begin
        m_active = 1'b1; q.delete();
        exp_busy = 1'b1; exp_pass = 1'b0; exp_fc = 2'd0;
      end
    end else begin
      q.push_back(d);
      evaluate(dec, p, fc);
      if (dec) begin
        m_active = 1'b0; m_result = 1'b1; m_decided_at = q.size();
        exp_busy = 1'b0; exp_done = 1'b1; exp_pass = p; exp_fc = fc;
      end
    end
  endtask

  // One clock: drive at negedge, model at posedge, compare at next negedge.
  task automatic step(input bit s, input bit d, input bit r);
    start = s; din = d; rst = r;
    @(posedge clk);
    model_step(s, d, r);
    @(negedge clk);
    vectors++;
    if (done === 1'b1) done_seen++;
    if ({busy, done, pass, fail_code} !== {exp_busy, exp_done, exp_pass, exp_fc}) begin
      miscompares++;
      $display("FAIL cycle_compare t=%0t: busy/done/pass/fc got %b/%b/%b/%0d expected %b/%b/%b/%0d",
               $time, busy, done, pass, fail_code, exp_busy, exp_done, exp_pass, exp_fc);
    end
  endtask

  task automatic add_run(input bit v, input int n);
    for (int i = 0; i < n; i++) pat.push_back(v);
  endtask

  // Start a check, feed pat until the model decides, then the RESULT and one idle cycle.
  task automatic run_pattern(input bit noise, output int dec_at);
    dec_at = 0;
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < pat.size(); i++) begin
      step(noise ? 1'($urandom_range(0, 1)) : 1'b0, pat[i], 1'b0);
      if (m_result) begin
        dec_at = m_decided_at;
        break;
      end
    end
    if (dec_at == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL pattern_timeout: no decision after %0d samples, expected one", pat.size());
    end
    step(noise, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic directed(input string name, input int at, input bit p, input int fc);
    int dec_at;
    int d0 = done_seen;
    run_pattern(1'b0, dec_at);
    check({name, "_decide_sample"}, dec_at, at);
    check({name, "_model_pass"}, int'(exp_pass), int'(p));
    check({name, "_model_fc"}, int'(exp_fc), fc);
    check({name, "_dut_pass"}, int'(pass), int'(p));
    check({name, "_dut_fc"}, int'(fail_code), fc);
    check({name, "_done_count"}, done_seen - d0, 1);
  endtask

  initial begin
    int dec_at, d0;
    start = 1'b0; din = 1'b0; rst = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_pass", int'(pass), 0);
    check("reset_fc", int'(fail_code), 0);
    step(1'b0, 1'b0, 1'b0);

    pat.delete(); add_run(0, 20); add_run(1, 20); add_run(0, 20);
    directed("nominal", 58, 1'b1, 0);
    pat.delete(); add_run(0, 17); add_run(1, 5);
    directed("low1_short", 18, 1'b0, 1);
    pat.delete(); add_run(0, 20); add_run(1, 30);
    directed("high_long", 43, 1'b0, 2);
    pat.delete(); add_run(0, 22); add_run(1, 18); add_run(0, 5); add_run(1, 1); add_run(0, 10);
    directed("low2_glitch", 46, 1'b0, 3);
    pat.delete(); add_run(0, 23); add_run(1, 20);
    directed("low1_long", 23, 1'b0, 1);
    pat.delete(); add_run(0, 22); add_run(1, 22); add_run(0, 18);
    directed("max_edges", 62, 1'b1, 0);
    pat.delete(); add_run(0, 18); add_run(1, 17); add_run(0, 20);
    directed("high_short", 36, 1'b0, 2);
    pat.delete(); add_run(1, 3);
    directed("immediate_high", 1, 1'b0, 1);

    // reset during HIGH: everything clears, no done
    d0 = done_seen;
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    check("abort_busy", int'(busy), 0);
    check("abort_no_done", done_seen - d0, 0);
    step(1'b0, 1'b0, 1'b0);
    pat.delete(); add_run(0, 20); add_run(1, 20); add_run(0, 20);
    directed("after_abort", 58, 1'b1, 0);

    // start re-pulsed while busy and during RESULT
    d0 = done_seen;
    run_pattern(1'b1, dec_at);
    check("restart_decide_sample", dec_at, 58);
    check("restart_single_done", done_seen - d0, 1);
    check("restart_pass", int'(pass), 1);

    // randomized patterns around the window edges
    for (int k = 0; k < 150; k++) begin
      pat.delete();
      add_run(0, $urandom_range(LO - 3, HI + 2));
      add_run(1, $urandom_range(LO - 3, HI + 2));
      add_run(0, $urandom_range(0, LO + 2));
      add_run(1, 1);
      add_run(0, 30);
      run_pattern(($urandom_range(0, 3) == 0), dec_at);
    end

    // free-running random inputs with rare resets
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 199) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
